// File: rtl/device_select.sv
// device_select: device-side control unit for one parallel-channel address.
// Recognises its address, captures or propagates select, and runs the
// initial-selection sequence: address-in, then command-out, then status-in.
// Each tag is sampled on one edge and answered on the next.
// All outputs are registered.
module device_select #(
    parameter logic [7:0] ADDRESS = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    // channel outbound side
    input  logic [7:0] bus_out,
    input  logic       operational_out,
    input  logic       hold_out,
    input  logic       address_out,
    input  logic       command_out,
    input  logic       service_out,
    input  logic       selection_x,
    // channel inbound side
    output logic [7:0] bus_in,
    output logic       operational_in,
    output logic       address_in,
    output logic       status_in,
    output logic       request_in,
    output logic       service_in,
    output logic       selection_y,
    // local device logic
    input  logic [7:0] status,
    output logic [7:0] cmd,
    output logic       cmd_valid,
    output logic       status_accepted,
    output logic       status_stacked
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDRESSED,
        S_SELECTED,
        S_ADDR_IN,
        S_CMD_DROP,
        S_STATUS_IN,
        S_STATUS_DROP,
        S_DISCONNECT
    } state_t;

    state_t r_state;

    // This block never raises requests or data-service on its own.
    assign request_in = 1'b0;
    assign service_in = 1'b0;

    // Selection state machine with registered tag, bus and pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            bus_in          <= 8'h00;
            operational_in  <= 1'b0;
            address_in      <= 1'b0;
            status_in       <= 1'b0;
            selection_y     <= 1'b0;
            cmd             <= 8'h00;
            cmd_valid       <= 1'b0;
            status_accepted <= 1'b0;
            status_stacked  <= 1'b0;
        end else if (!operational_out) begin
            // Channel disconnect: drop everything but keep the last command.
            r_state         <= S_IDLE;
            bus_in          <= 8'h00;
            operational_in  <= 1'b0;
            address_in      <= 1'b0;
            status_in       <= 1'b0;
            selection_y     <= 1'b0;
            cmd_valid       <= 1'b0;
            status_accepted <= 1'b0;
            status_stacked  <= 1'b0;
        end else begin
            cmd_valid       <= 1'b0;
            status_accepted <= 1'b0;
            status_stacked  <= 1'b0;
            // Select is only passed on while idle.
            selection_y     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    selection_y <= selection_x;
                    // A match after select has already passed belongs downstream.
                    if (address_out && bus_out == ADDRESS && !selection_x)
                        r_state <= S_ADDRESSED;
                end
                S_ADDRESSED: begin
                    if (selection_x) begin
                        operational_in <= 1'b1;
                        r_state        <= S_SELECTED;
                    end else if (!address_out) begin
                        r_state <= S_IDLE;
                    end
                end
                S_SELECTED: begin
                    if (!address_out) begin
                        bus_in     <= ADDRESS;
                        address_in <= 1'b1;
                        r_state    <= S_ADDR_IN;
                    end
                end
                S_ADDR_IN: begin
                    if (command_out) begin
                        cmd        <= bus_out;
                        cmd_valid  <= 1'b1;
                        address_in <= 1'b0;
                        bus_in     <= 8'h00;
                        r_state    <= S_CMD_DROP;
                    end
                end
                S_CMD_DROP: begin
                    if (!command_out) begin
                        bus_in    <= status;
                        status_in <= 1'b1;
                        r_state   <= S_STATUS_IN;
                    end
                end
                S_STATUS_IN: begin
                    if (service_out || command_out) begin
                        // Acceptance takes precedence over stacking.
                        status_accepted <= service_out;
                        status_stacked  <= !service_out;
                        status_in       <= 1'b0;
                        bus_in          <= 8'h00;
                        r_state         <= S_STATUS_DROP;
                    end
                end
                S_STATUS_DROP: begin
                    if (!service_out && !command_out)
                        r_state <= S_DISCONNECT;
                end
                S_DISCONNECT: begin
                    if (!selection_x && !hold_out) begin
                        operational_in <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_device_select.sv
// tb_device_select: directed table of per-cycle inputs and expected outputs
// for device_select at ADDRESS 8'h2A.
module tb_device_select;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] bus_out;
    logic       operational_out, hold_out, address_out, command_out, service_out, selection_x;
    logic [7:0] bus_in;
    logic       operational_in, address_in, status_in, request_in, service_in, selection_y;
    logic [7:0] status;
    logic [7:0] cmd;
    logic       cmd_valid, status_accepted, status_stacked;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    device_select #(.ADDRESS(8'h2A)) dut (
        .clk(clk), .reset(reset),
        .bus_out(bus_out), .operational_out(operational_out), .hold_out(hold_out),
        .address_out(address_out), .command_out(command_out), .service_out(service_out),
        .selection_x(selection_x),
        .bus_in(bus_in), .operational_in(operational_in), .address_in(address_in),
        .status_in(status_in), .request_in(request_in), .service_in(service_in),
        .selection_y(selection_y),
        .status(status), .cmd(cmd), .cmd_valid(cmd_valid),
        .status_accepted(status_accepted), .status_stacked(status_stacked)
    );

    typedef struct {
        logic       rst, op, hold, ao, co, so, sx;
        logic [7:0] bo, st;
        logic [7:0] e_bi, e_cmd;
        logic       e_opi, e_ai, e_si, e_sy, e_cv, e_sa, e_ss;
    } vec_t;

    vec_t tbl[$];

    // One row: inputs held through one rising edge, then outputs expected after it.
    task automatic add(input logic rst, input logic op, input logic [7:0] bo,
                       input logic hold, input logic ao, input logic co, input logic so,
                       input logic sx, input logic [7:0] st,
                       input logic [7:0] bi, input logic opi, input logic ai, input logic si,
                       input logic sy, input logic [7:0] c, input logic cv,
                       input logic sa, input logic ss);
        vec_t v;
        v.rst = rst; v.op = op; v.bo = bo; v.hold = hold; v.ao = ao; v.co = co;
        v.so = so; v.sx = sx; v.st = st;
        v.e_bi = bi; v.e_opi = opi; v.e_ai = ai; v.e_si = si; v.e_sy = sy;
        v.e_cmd = c; v.e_cv = cv; v.e_sa = sa; v.e_ss = ss;
        tbl.push_back(v);
    endtask

    function automatic logic [28:0] pack_act();
        return {bus_in, operational_in, address_in, status_in, selection_y,
                request_in, service_in, cmd, cmd_valid, status_accepted, status_stacked, 2'b00};
    endfunction

    task automatic check(input string name, input logic [28:0] act, input logic [28:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        reset = 1; operational_out = 0; bus_out = 0; hold_out = 0; address_out = 0;
        command_out = 0; service_out = 0; selection_x = 0; status = 0;

        //   rst op bo     hd ao co so sx st       bi     opi ai si sy cmd   cv sa ss
        // main sequence: select, address-in, command, status accepted, disconnect
        add(1, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h2A, 0, 1, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h2A, 0, 1, 0, 0, 1, 8'h00,   8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h2A, 0, 1, 0, 0, 1, 8'h00,   8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h00, 1, 0, 0, 0, 1, 8'h00,   8'h2A, 1, 1, 0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h02, 1, 0, 1, 0, 1, 8'h00,   8'h00, 1, 0, 0, 0, 8'h02, 1, 0, 0);
        add(0, 1, 8'h02, 1, 0, 1, 0, 1, 8'h0C,   8'h00, 1, 0, 0, 0, 8'h02, 0, 0, 0);
        add(0, 1, 8'h00, 1, 0, 0, 0, 1, 8'h0C,   8'h0C, 1, 0, 1, 0, 8'h02, 0, 0, 0);
        add(0, 1, 8'h00, 1, 0, 0, 0, 1, 8'h0C,   8'h0C, 1, 0, 1, 0, 8'h02, 0, 0, 0);
        add(0, 1, 8'h00, 1, 0, 0, 1, 1, 8'h0C,   8'h00, 1, 0, 0, 0, 8'h02, 0, 1, 0);
        add(0, 1, 8'h00, 1, 0, 0, 1, 1, 8'h00,   8'h00, 1, 0, 0, 0, 8'h02, 0, 0, 0);
        add(0, 1, 8'h00, 1, 0, 0, 0, 1, 8'h00,   8'h00, 1, 0, 0, 0, 8'h02, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 1, 8'h00,   8'h00, 1, 0, 0, 0, 8'h02, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0, 0, 8'h02, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0, 0, 8'h02, 0, 0, 0);
        // other address: select passes through with one cycle delay
        add(0, 1, 8'h2B, 0, 1, 0, 0, 1, 8'h00,   8'h00, 0, 0, 0, 1, 8'h02, 0, 0, 0);
        add(0, 1, 8'h2B, 0, 1, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0, 0, 8'h02, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 1, 8'h00,   8'h00, 0, 0, 0, 1, 8'h02, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0, 0, 8'h02, 0, 0, 0);
        // own address with select already high: ignored, keeps propagating
        add(0, 1, 8'h2A, 0, 1, 0, 0, 1, 8'h00,   8'h00, 0, 0, 0, 1, 8'h02, 0, 0, 0);
        // match without select, then address_out drops: back to IDLE
        add(0, 1, 8'h2A, 0, 1, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0, 0, 8'h02, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0, 0, 8'h02, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 1, 8'h00,   8'h00, 0, 0, 0, 1, 8'h02, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0, 0, 8'h02, 0, 0, 0);
        // status stacked with command_out
        add(0, 1, 8'h2A, 0, 1, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0, 0, 8'h02, 0, 0, 0);
        add(0, 1, 8'h2A, 0, 1, 0, 0, 1, 8'h00,   8'h00, 1, 0, 0, 0, 8'h02, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 1, 8'h00,   8'h2A, 1, 1, 0, 0, 8'h02, 0, 0, 0);
        add(0, 1, 8'h05, 0, 0, 1, 0, 1, 8'h00,   8'h00, 1, 0, 0, 0, 8'h05, 1, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 1, 8'h33,   8'h33, 1, 0, 1, 0, 8'h05, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 1, 0, 1, 8'h00,   8'h00, 1, 0, 0, 0, 8'h05, 0, 0, 1);
        add(0, 1, 8'h00, 0, 0, 1, 0, 1, 8'h00,   8'h00, 1, 0, 0, 0, 8'h05, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 1, 8'h00,   8'h00, 1, 0, 0, 0, 8'h05, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0, 0, 8'h05, 0, 0, 0);
        // service_out and command_out together: acceptance wins
        add(0, 1, 8'h2A, 0, 1, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0, 0, 8'h05, 0, 0, 0);
        add(0, 1, 8'h2A, 0, 1, 0, 0, 1, 8'h00,   8'h00, 1, 0, 0, 0, 8'h05, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 1, 8'h00,   8'h2A, 1, 1, 0, 0, 8'h05, 0, 0, 0);
        add(0, 1, 8'h07, 0, 0, 1, 0, 1, 8'h00,   8'h00, 1, 0, 0, 0, 8'h07, 1, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 1, 8'h44,   8'h44, 1, 0, 1, 0, 8'h07, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 1, 1, 1, 8'h00,   8'h00, 1, 0, 0, 0, 8'h07, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00,   8'h00, 1, 0, 0, 0, 8'h07, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0, 0, 8'h07, 0, 0, 0);
        // operational_out drops in ADDR_IN, then a clean new sequence
        add(0, 1, 8'h2A, 0, 1, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0, 0, 8'h07, 0, 0, 0);
        add(0, 1, 8'h2A, 0, 1, 0, 0, 1, 8'h00,   8'h00, 1, 0, 0, 0, 8'h07, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 1, 8'h00,   8'h2A, 1, 1, 0, 0, 8'h07, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0, 1, 8'h00,   8'h00, 0, 0, 0, 0, 8'h07, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0, 0, 8'h07, 0, 0, 0);
        add(0, 1, 8'h2A, 0, 1, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0, 0, 8'h07, 0, 0, 0);
        add(0, 1, 8'h2A, 0, 1, 0, 0, 1, 8'h00,   8'h00, 1, 0, 0, 0, 8'h07, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 1, 8'h00,   8'h2A, 1, 1, 0, 0, 8'h07, 0, 0, 0);
        add(0, 1, 8'h09, 0, 0, 1, 0, 1, 8'h00,   8'h00, 1, 0, 0, 0, 8'h09, 1, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 1, 8'h11,   8'h11, 1, 0, 1, 0, 8'h09, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 1, 1, 8'h00,   8'h00, 1, 0, 0, 0, 8'h09, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00,   8'h00, 1, 0, 0, 0, 8'h09, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0, 0, 8'h09, 0, 0, 0);
        // reset in STATUS_IN with service_out high: no pulse, cmd cleared
        add(0, 1, 8'h2A, 0, 1, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0, 0, 8'h09, 0, 0, 0);
        add(0, 1, 8'h2A, 0, 1, 0, 0, 1, 8'h00,   8'h00, 1, 0, 0, 0, 8'h09, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 1, 8'h00,   8'h2A, 1, 1, 0, 0, 8'h09, 0, 0, 0);
        add(0, 1, 8'h0A, 0, 0, 1, 0, 1, 8'h00,   8'h00, 1, 0, 0, 0, 8'h0A, 1, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 1, 8'h22,   8'h22, 1, 0, 1, 0, 8'h0A, 0, 0, 0);
        add(1, 1, 8'h00, 0, 0, 0, 1, 1, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 1, 0, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset = tbl[i].rst; operational_out = tbl[i].op; bus_out = tbl[i].bo;
            hold_out = tbl[i].hold; address_out = tbl[i].ao; command_out = tbl[i].co;
            service_out = tbl[i].so; selection_x = tbl[i].sx; status = tbl[i].st;
            @(posedge clk);
            #1;
            check($sformatf("row%0d", i), pack_act(),
                  {tbl[i].e_bi, tbl[i].e_opi, tbl[i].e_ai, tbl[i].e_si, tbl[i].e_sy,
                   1'b0, 1'b0, tbl[i].e_cmd, tbl[i].e_cv, tbl[i].e_sa, tbl[i].e_ss, 2'b00});
        end

        // Hand sequence: select pulse while held in reset is never propagated,
        // and a matching address during reset does not start a selection.
        @(negedge clk);
        reset = 1; bus_out = 8'h2A; address_out = 1; selection_x = 1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset_hold%0d", k), pack_act(), 29'h0);
        end
        @(negedge clk);
        reset = 0; address_out = 0; selection_x = 0;
        @(posedge clk);
        #1;
        check("post_reset_idle", pack_act(), 29'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/device_select.md
# device_select

Device-side control unit for one parallel-channel device address. It sits directly downstream of the channel tee's device port: it consumes the tee's outbound bus and tag lines plus `selection_x`, and drives the tee's inbound bus and tag lines plus `selection_y`. It recognises its address, captures or propagates select, runs the initial-selection sequence (address-in, command-out, status-in), and hands the command byte to local device logic.

## Interface
- `ADDRESS`, 8'h00: device address this block answers to.
- `clk` input 1: single clock; all logic on posedge.
- `reset` input 1: synchronous, active-high.
- `bus_out` input 8: channel outbound bus.
- `operational_out` input 1: channel operational; low forces the disconnect described in Operation.
- `hold_out`, `address_out`, `command_out`, `service_out` inputs 1: channel outbound tags.
- `selection_x` input 1: select arriving from the tee.
- `bus_in` output 8: inbound bus toward the tee.
- `operational_in`, `address_in`, `status_in` outputs 1: inbound tags.
- `request_in`, `service_in` outputs 1: constant 0 in this block.
- `selection_y` output 1: select propagated onward.
- `status` input 8: initial status byte from local logic.
- `cmd` output 8: last captured command byte.
- `cmd_valid` output 1: one-cycle pulse when `cmd` is updated.
- `status_accepted` output 1: one-cycle pulse when the channel accepts status with `service_out`.
- `status_stacked` output 1: one-cycle pulse when the channel stacks status with `command_out`.

## Operation
All outputs are registered. Every tag decision is taken on the cycle a condition is sampled and appears at the outputs on the next edge.

States and transitions:
- **IDLE**: `selection_y <= selection_x`.
  - If `address_out && bus_out == ADDRESS && !selection_x`, go to ADDRESSED.
  - An address match while `selection_x` is already high is ignored: select has already passed, so the block stays in IDLE and keeps propagating.
- **ADDRESSED**: `selection_y` = 0.
  - `selection_x` rises: set `operational_in`, go to SELECTED.
  - `address_out` drops first: go to IDLE.
- **SELECTED**: wait for `!address_out`. Then drive `bus_in = ADDRESS`, set `address_in`, and go to ADDR_IN.
- **ADDR_IN**: wait for `command_out`.
  - Then: `cmd <= bus_out`, pulse `cmd_valid`, clear `address_in`, `bus_in <= 0`, go to CMD_DROP.
- **CMD_DROP**: wait for `!command_out`. Then `bus_in <= status` (sampled this cycle), set `status_in`, go to STATUS_IN.
- **STATUS_IN**: wait for `service_out` or `command_out`.
  - `service_out` pulses `status_accepted`; `command_out` pulses `status_stacked`.
  - If both are high on the same cycle, `service_out` wins: only `status_accepted` pulses.
  - Clear `status_in`, `bus_in <= 0`, go to STATUS_DROP.
- **STATUS_DROP**: wait for `!service_out && !command_out`. Then go to DISCONNECT.
- **DISCONNECT**: wait for `!selection_x && !hold_out`. Then clear `operational_in` and go to IDLE.

Global rules:
- In every state other than IDLE, `selection_y` = 0. The block never propagates select while it holds the interface.
- `operational_out` low, sampled in any state, takes priority over every transition. On the next edge: state = IDLE, all outputs 0, `selection_y` = 0, `cmd` retained, no pulses.
- `reset` high gives the same result as `operational_out` low, and additionally clears `cmd`.
- `reset` mid-sequence abandons the sequence with no pulse output.

## Timing
- Reset value of every output: 0, including `cmd`.
- Select propagation when not addressed: `selection_y` follows `selection_x` with 1-cycle latency.
- Tag response latency: 1 cycle from the sampled tag edge to the inbound tag change.
  - Example: `command_out` high at edge n gives `address_in` low and `cmd_valid` high at edge n+1.
- `bus_in` changes on the same edge as the tag it qualifies: data valid whenever `address_in` or `status_in` is high.
- Pulse outputs are exactly 1 cycle wide. There is at most one `cmd_valid` per selection.
- `status` is sampled only on the CMD_DROP exit cycle. Local logic must hold it valid from `cmd_valid` onward.

## Test plan
- `ADDRESS`=8'h2A, `bus_out`=8'h2A with `address_out`, then `selection_x`:
  - `operational_in`=1 one cycle after select; `selection_y` stays 0.
  - After `address_out` drops: `address_in`=1 with `bus_in`=8'h2A.
- Continue with `command_out` and `bus_out`=8'h02, then drop `command_out` with `status`=8'h0C:
  - `cmd`=8'h02 and `cmd_valid` 1-cycle pulse.
  - Then `status_in`=1 with `bus_in`=8'h0C.
  - `service_out` gives a `status_accepted` pulse and `status_in` low.
  - Dropping `selection_x` and `hold_out` gives `operational_in`=0 and the IDLE state.
- `bus_out`=8'h2B with `address_out` and `selection_x` pulse: `selection_y` copies `selection_x` delayed 1 cycle; `operational_in` stays 0.
- `command_out` in STATUS_IN: `status_stacked` pulses once and `status_accepted` stays 0. Same cycle `service_out` and `command_out`: only `status_accepted` pulses.
- Drop `operational_out` while in ADDR_IN: next cycle all tags and `bus_in` are 0, and a new address sequence completes normally.
- Assert `reset` in STATUS_IN: all outputs 0 next cycle, `cmd`=8'h00, no pulses.
